// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory access and
// writeback all complete within one clock period. Program and data memories
// are byte arrays that are never cleared by reset, so they can be preloaded
// before the core starts. Both memory sizes must be powers of two, which lets
// the address reduction modulo the memory size be a plain bit slice.

// Program memory: word-aligned combinational read of PM, little-endian.
module rv32i_prog_mem #(
    parameter int PM_BYTES = 128,
    localparam int AW = $clog2(PM_BYTES)
) (
    input  logic          clk,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic [AW-3:0] word_idx,
    output logic [31:0]   word
);
    logic [7:0] PM [0:PM_BYTES-1];

    assign word = {PM[{word_idx, 2'd3}], PM[{word_idx, 2'd2}],
                   PM[{word_idx, 2'd1}], PM[{word_idx, 2'd0}]};

    // Byte load port for a boot loader; program images can also be placed
    // directly into PM before reset is released.
    // NOTE: memory arrays get no reset branch; clearing them would cost a
    // reset path per bit and would destroy a preloaded image.
    always_ff @(posedge clk) begin
        if (load_en) begin
            PM[load_addr] <= load_data;
        end
    end
endmodule

// Data memory: word-aligned combinational read, word write at the clock edge.
module rv32i_data_mem #(
    parameter int DM_BYTES = 128,
    localparam int AW = $clog2(DM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-3:0] word_idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [7:0]    byte_4,
    output logic [7:0]    byte_12
);
    logic [7:0] DM [0:DM_BYTES-1];

    assign rdata   = {DM[{word_idx, 2'd3}], DM[{word_idx, 2'd2}],
                      DM[{word_idx, 2'd1}], DM[{word_idx, 2'd0}]};
    assign byte_4  = DM[4];
    assign byte_12 = DM[12];

    // Store one little-endian word when a sw commits.
    always_ff @(posedge clk) begin
        if (we) begin
            DM[{word_idx, 2'd0}] <= wdata[7:0];
            DM[{word_idx, 2'd1}] <= wdata[15:8];
            DM[{word_idx, 2'd2}] <= wdata[23:16];
            DM[{word_idx, 2'd3}] <= wdata[31:24];
        end
    end
endmodule

module rv32i_single_cycle_core #(
    parameter int PM_BYTES = 128,
    parameter int DM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm_extended,
    output logic [31:0] ALU_result,
    output logic [31:0] mem_adr,
    output logic [7:0]  DM_4,
    output logic [7:0]  DM_12,
    output logic [7:0]  X0,
    output logic [7:0]  X1,
    output logic [7:0]  X2,
    output logic [7:0]  X3,
    output logic [7:0]  X4,
    output logic [7:0]  X5,
    output logic [7:0]  X6,
    output logic [7:0]  X7,
    output logic [7:0]  X8
);
    localparam int PM_AW = $clog2(PM_BYTES);
    localparam int DM_AW = $clog2(DM_BYTES);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    opcode_e     opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] regs [0:31];
    logic [31:0] alu_b, dm_rdata, wb_data, next_pc;
    logic [4:0]  shamt;
    logic [2:0]  alu_f3;
    logic        alu_alt, use_imm, reg_write, wb_from_mem, mem_write;
    logic        branch_en, branch_ne, branch_taken;

    rv32i_prog_mem #(.PM_BYTES(PM_BYTES)) pm_module (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr ('0),
        .load_data (8'h00),
        .word_idx  (PC[PM_AW-1:2]),
        .word      (instruction)
    );

    rv32i_data_mem #(.DM_BYTES(DM_BYTES)) dm_module (
        .clk      (clk),
        .we       (mem_write),
        .word_idx (ALU_result[DM_AW-1:2]),
        .wdata    (rs2_data),
        .rdata    (dm_rdata),
        .byte_4   (DM_4),
        .byte_12  (DM_12)
    );

    assign opcode = opcode_e'(instruction[6:0]);
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    // Decode: immediate format, ALU operation and commit enables per opcode.
    // NOTE: every output of this block is assigned a default first, so no
    // path through the case can leave a signal holding and infer a latch.
    always_comb begin
        imm_extended = 32'd0;
        alu_f3       = 3'b000;
        alu_alt      = 1'b0;
        use_imm      = 1'b0;
        reg_write    = 1'b0;
        wb_from_mem  = 1'b0;
        mem_write    = 1'b0;
        branch_en    = 1'b0;
        branch_ne    = 1'b0;
        case (opcode)
            OP_R: begin
                alu_f3    = funct3;
                alu_alt   = instruction[30];
                reg_write = 1'b1;
            end
            OP_IMM: begin
                imm_extended = {{20{instruction[31]}}, instruction[31:20]};
                use_imm      = 1'b1;
                alu_f3       = funct3;
                // Only srai uses bit 30 as an opcode bit; elsewhere it is immediate.
                alu_alt      = (funct3 == 3'b101) && instruction[30];
                reg_write    = 1'b1;
            end
            OP_LOAD: begin
                imm_extended = {{20{instruction[31]}}, instruction[31:20]};
                use_imm      = 1'b1;
                reg_write    = (funct3 == 3'b010);
                wb_from_mem  = 1'b1;
            end
            OP_STORE: begin
                imm_extended = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                use_imm      = 1'b1;
                mem_write    = (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                imm_extended = {{19{instruction[31]}}, instruction[31], instruction[7],
                                instruction[30:25], instruction[11:8], 1'b0};
                alu_alt      = 1'b1;
                branch_en    = (funct3 == 3'b000) || (funct3 == 3'b001);
                branch_ne    = funct3[0];
            end
            default: ;
        endcase
    end

    assign alu_b = use_imm ? imm_extended : rs2_data;
    assign shamt = alu_b[4:0];

    // ALU, selected by funct3 with bit 30 choosing sub / arithmetic shift.
    always_comb begin
        case (alu_f3)
            3'b000:  ALU_result = alu_alt ? (rs1_data - alu_b) : (rs1_data + alu_b);
            3'b001:  ALU_result = rs1_data << shamt;
            3'b010:  ALU_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
            3'b011:  ALU_result = {31'd0, rs1_data < alu_b};
            3'b100:  ALU_result = rs1_data ^ alu_b;
            3'b101: begin
                if (alu_alt) begin
                    ALU_result = $signed(rs1_data) >>> shamt;
                end else begin
                    ALU_result = rs1_data >> shamt;
                end
            end
            3'b110:  ALU_result = rs1_data | alu_b;
            default: ALU_result = rs1_data & alu_b;
        endcase
    end

    assign mem_adr      = ALU_result;
    assign wb_data      = wb_from_mem ? dm_rdata : ALU_result;
    assign branch_taken = branch_en && ((ALU_result == 32'd0) != branch_ne);
    assign next_pc      = branch_taken ? (PC + imm_extended) : (PC + 32'd4);

    // Program counter: one instruction committed per clock.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC <= 32'd0;
        end else begin
            PC <= next_pc;
        end
    end

    // Register file write port; x0 is never written and always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (reg_write && (rd != 5'd0)) begin
            regs[rd] <= wb_data;
        end
    end

    assign X0 = 8'h00;
    assign X1 = regs[1][7:0];
    assign X2 = regs[2][7:0];
    assign X3 = regs[3][7:0];
    assign X4 = regs[4][7:0];
    assign X5 = regs[5][7:0];
    assign X6 = regs[6][7:0];
    assign X7 = regs[7][7:0];
    assign X8 = regs[8][7:0];
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: an instruction-level model of the core
// runs alongside the DUT; a compare process checks every observation port on
// each falling edge. A directed program pins the model with literal values,
// then random programs exercise the full instruction subset.
module tb_rv32i_single_cycle_core;
    localparam int PM_BYTES = 128;
    localparam int DM_BYTES = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC, instruction, rs1_data, rs2_data, imm_extended, ALU_result, mem_adr;
    logic [7:0]  DM_4, DM_12, X0, X1, X2, X3, X4, X5, X6, X7, X8;
    logic [7:0]  xo [0:8];

    rv32i_single_cycle_core #(.PM_BYTES(PM_BYTES), .DM_BYTES(DM_BYTES)) dut (
        .clk(clk), .reset(reset), .PC(PC), .instruction(instruction),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_extended(imm_extended),
        .ALU_result(ALU_result), .mem_adr(mem_adr), .DM_4(DM_4), .DM_12(DM_12),
        .X0(X0), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5), .X6(X6), .X7(X7), .X8(X8)
    );

    always #5 clk = ~clk;

    assign xo[0] = X0; assign xo[1] = X1; assign xo[2] = X2;
    assign xo[3] = X3; assign xo[4] = X4; assign xo[5] = X5;
    assign xo[6] = X6; assign xo[7] = X7; assign xo[8] = X8;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    // Architectural model state.
    logic [31:0] m_pc;
    logic [31:0] m_x [32];
    logic [7:0]  m_pm [PM_BYTES];
    logic [7:0]  m_dm [DM_BYTES];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [31:0] alu;
        bit          alu_known;
    } exp_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t, model pc %h)", name, got, want, $time, m_pc);
        end
    endtask

    function automatic logic [31:0] pm_word(input logic [31:0] a);
        int unsigned b = ((a >> 2) % (PM_BYTES / 4)) * 4;
        return {m_pm[b + 3], m_pm[b + 2], m_pm[b + 1], m_pm[b]};
    endfunction

    function automatic int unsigned dm_base(input logic [31:0] a);
        return ((a >> 2) % (DM_BYTES / 4)) * 4;
    endfunction

    function automatic logic [31:0] alu_calc(input logic [2:0] f3, input bit alt,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh = b % 32;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> sh;
                else     r = a >> sh;
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // What the core must show for the current model state.
    function automatic exp_t model_eval();
        exp_t e;
        logic [31:0] i;
        i = pm_word(m_pc);
        e.inst = i;
        e.rs1v = m_x[i[19:15]];
        e.rs2v = m_x[i[24:20]];
        e.alu_known = 1'b1;
        case (i[6:0])
            7'h13, 7'h03: e.imm = {{20{i[31]}}, i[31:20]};
            7'h23:        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63:        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default:      e.imm = 32'd0;
        endcase
        case (i[6:0])
            7'h33:        e.alu = alu_calc(i[14:12], i[30], e.rs1v, e.rs2v);
            7'h13:        e.alu = alu_calc(i[14:12], (i[14:12] == 3'd5) && i[30], e.rs1v, e.imm);
            7'h03, 7'h23: e.alu = e.rs1v + e.imm;
            7'h63:        e.alu = e.rs1v - e.rs2v;
            default: begin
                e.alu = 32'd0;
                e.alu_known = 1'b0;
            end
        endcase
        return e;
    endfunction

    // Commit one instruction in the model.
    task automatic model_step();
        exp_t e = model_eval();
        logic [4:0] rd = e.inst[11:7];
        logic [2:0] f3 = e.inst[14:12];
        int unsigned b;
        bit taken = 1'b0;
        case (e.inst[6:0])
            7'h33, 7'h13: if (rd != 0) m_x[rd] = e.alu;
            7'h03: begin
                b = dm_base(e.alu);
                if (f3 == 3'd2 && rd != 0) m_x[rd] = {m_dm[b + 3], m_dm[b + 2], m_dm[b + 1], m_dm[b]};
            end
            7'h23: begin
                b = dm_base(e.alu);
                if (f3 == 3'd2) {m_dm[b + 3], m_dm[b + 2], m_dm[b + 1], m_dm[b]} = e.rs2v;
            end
            7'h63: begin
                if (f3 == 3'd0) taken = (e.rs1v == e.rs2v);
                if (f3 == 3'd1) taken = (e.rs1v != e.rs2v);
            end
            default: ;
        endcase
        m_pc = taken ? m_pc + e.imm : m_pc + 32'd4;
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    endtask

    task automatic put_pm_word(input int w, input logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            m_pm[4 * w + k] = v[8 * k +: 8];
            dut.pm_module.PM[4 * w + k] = v[8 * k +: 8];
        end
    endtask

    task automatic put_dm_byte(input int a, input logic [7:0] v);
        m_dm[a] = v;
        dut.dm_module.DM[a] = v;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd  = 5'($urandom_range(31));
        logic [4:0]  rs1 = 5'($urandom_range(31));
        logic [4:0]  rs2 = 5'($urandom_range(31));
        logic [2:0]  f3  = 3'($urandom_range(7));
        logic [11:0] imm = 12'($urandom);
        logic [6:0]  f7;
        logic [12:0] off;
        int          kind = $urandom_range(9);
        case (kind)
            0, 1: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(1) == 1) ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            2, 3: begin
                if (f3 == 3'd1) imm = {7'h00, rs2};
                if (f3 == 3'd5) imm = {($urandom_range(1) == 1) ? 7'h20 : 7'h00, rs2};
                return {imm, rs1, f3, rd, 7'h13};
            end
            4: return {imm, rs1, 3'b010, rd, 7'h03};
            5: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            6: begin
                off = 13'(int'($urandom_range(8) * 4) - 16);
                return {off[12], off[10:5], rs2, rs1, 2'b00, 1'($urandom_range(1)),
                        off[4:1], off[11], 7'h63};
            end
            7: begin
                case ($urandom_range(2))
                    0:       return 32'h0000_0000;
                    1:       return {20'($urandom), rd, 7'h37};
                    default: return {20'($urandom), rd, 7'h6F};
                endcase
            end
            default: return {imm, rs1, 3'b000, 5'($urandom_range(8, 1)), 7'h13};
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model commits alongside the DUT on every enabled rising edge.
    always @(posedge clk) begin
        if (check_en && reset) model_step();
    end

    // Compare every observation port against the model on each falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (check_en) begin
            e = model_eval();
            check("pc", PC, m_pc);
            check("instruction", instruction, e.inst);
            check("rs1_data", rs1_data, e.rs1v);
            check("rs2_data", rs2_data, e.rs2v);
            check("imm_extended", imm_extended, e.imm);
            if (e.alu_known) begin
                check("alu_result", ALU_result, e.alu);
                check("mem_adr", mem_adr, e.alu);
            end
            for (int i = 0; i < 9; i++) check($sformatf("x%0d", i), xo[i], m_x[i][7:0]);
            check("dm_4", DM_4, m_dm[4]);
            check("dm_12", DM_12, m_dm[12]);
        end
    end

    logic [31:0] prog [11] = '{32'h00800093, 32'h0040A103, 32'h002081B3, 32'h40118233,
                               32'h0040E2B3, 32'h0012E313, 32'h00612023, 32'h004123B3,
                               32'h00812413, 32'hFE518AE3, 32'h00000000};

    initial begin
        #1 reset = 1'b0;
        for (int w = 0; w < PM_BYTES / 4; w++) put_pm_word(w, (w < 11) ? prog[w] : 32'd0);
        for (int a = 0; a < DM_BYTES; a++) put_dm_byte(a, (a <= 8) ? 8'(a) : 8'h00);
        put_dm_byte(12, 8'd4);
        model_reset();
        check_en = 1'b1;

        @(negedge clk); #2;
        check("rst_pc", PC, 32'd0);
        for (int i = 0; i < 9; i++) check($sformatf("rst_x%0d", i), xo[i], 32'd0);
        reset = 1'b1;
        #1;
        check("first_inst", instruction, 32'h00800093);
        check("first_imm", imm_extended, 32'd8);

        step(1);
        check("lw_pc", PC, 32'd4);
        check("lw_mem_adr", mem_adr, 32'd12);
        step(5);
        check("pc_24", PC, 32'd24);
        check("lit_x1", X1, 32'd8);
        check("lit_x2", X2, 32'd4);
        check("lit_x3", X3, 32'd12);
        check("lit_x4", X4, 32'd4);
        check("lit_x5", X5, 32'd12);
        check("lit_x6", X6, 32'd13);
        check("model_x6", m_x[6], 32'd13);
        check("sw_mem_adr", mem_adr, 32'd4);
        step(1);
        check("sw_dm_4", DM_4, 32'd13);
        check("sw_dm_12", DM_12, 32'd4);
        step(2);
        check("pc_36", PC, 32'd36);
        check("lit_x7", X7, 32'd0);
        check("lit_x8", X8, 32'd1);
        check("beq_imm", imm_extended, 32'hFFFF_FFF4);
        check("beq_alu", ALU_result, 32'd0);
        step(1);
        check("beq_taken_pc", PC, 32'd24);
        check("model_pc_24", m_pc, 32'd24);
        step(12);
        check("loop_pc", PC, 32'd24);
        check("loop_x6", X6, 32'd13);
        check("loop_x8", X8, 32'd1);
        step(1);
        check("pre_reset_pc", PC, 32'd28);

        // Mid-loop reset takes effect without a clock edge.
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_pc", PC, 32'd0);
        for (int i = 1; i < 9; i++) check($sformatf("midrst_x%0d", i), xo[i], 32'd0);
        check("midrst_dm_4", DM_4, 32'd13);

        // Random programs, each started from reset with fresh memory images.
        for (int p = 0; p < 4; p++) begin
            reset = 1'b0;
            model_reset();
            for (int w = 0; w < PM_BYTES / 4; w++) put_pm_word(w, rand_inst());
            for (int a = 0; a < DM_BYTES; a++) put_dm_byte(a, 8'($urandom));
            @(negedge clk); #2;
            reset = 1'b1;
            step(300);
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv32i_single_cycle_core.md
Name: rv32i_single_cycle_core

Overview:
Single-cycle RV32I-subset processor: fetch, decode, execute, memory and writeback all complete in one clock.
- Internal byte-wide program memory and data memory.
- 32x32 register file.
- Key datapath signals and selected register/memory bytes are exported as observation ports for bench and waveform checking.
- Top of the single_cycle design; the bench preloads both memories hierarchically.

Parameters:
- PM_BYTES, 128, program memory size in bytes
- DM_BYTES, 128, data memory size in bytes

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- PC  output  32  current program counter
- instruction  output  32  instruction fetched at PC
- rs1_data  output  32  register file read port 1 (rs1 = inst[19:15])
- rs2_data  output  32  register file read port 2 (rs2 = inst[24:20])
- imm_extended  output  32  sign-extended immediate for the current format
- ALU_result  output  32  ALU output
- mem_adr  output  32  data memory address (= ALU_result)
- DM_4  output  8  data memory byte 4
- DM_12  output  8  data memory byte 12
- X0..X8  output  8 each  low byte of registers x0..x8

Behaviour:
- Memory structure:
  - Instance pm_module holds byte array PM[0:PM_BYTES-1]; instance dm_module holds byte array DM[0:DM_BYTES-1].
  - Both arrays are hierarchically writable by the bench; neither is cleared by reset.
  - Little-endian: word = {M[a+3],M[a+2],M[a+1],M[a]}.
  - Addresses are reduced modulo size and word-aligned (low 2 bits ignored).
- Reset (reset=0, asynchronous):
  - PC=0; x1..x31 = 0.
  - All outputs then follow combinationally from PC=0 and the memory contents.
- Fetch/decode/execute:
  - Instruction fetch, register reads, immediate generation, ALU and data-memory reads are combinational from PC.
  - Each rising clk with reset=1 commits exactly one instruction: register write, memory write, PC update.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Reads are combinational; no internal write-through is needed in single-cycle operation.
- Immediates:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - All sign-extended to 32 bits. imm_extended = 0 for R-type and unknown opcodes.
- Supported instructions:
  - R-type (opcode 0110011): add, sub (funct7[5]=1), sll, slt, sltu, xor, srl, sra, or, and.
  - I-ALU (0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai. Shift amount = low 5 bits.
  - lw (0000011, funct3=010): rd <= DM word at rs1+imm.
  - sw (0100011, funct3=010): DM word at rs1+imm <= rs2 at the clock edge.
  - beq/bne (1100011, funct3 000/001): ALU computes rs1-rs2; if taken, PC <= PC+imm_B, else PC+4.
- Non-branch instructions: PC <= PC+4, 32-bit wrap.
- Unsupported opcodes (including 0x00000000): no-op with no register or memory write; PC+4.
- Arithmetic: 32-bit two's complement, overflow ignored. slt is signed, sltu unsigned; result 0 or 1.
- A load and a store to the same address cannot occur in one cycle. A store's effect is visible to the next cycle's load.
- Asserting reset mid-run restores PC=0 and clears registers at once; DM keeps stored values.

Test Plan:
- Preload program 0x00800093, 0x0040A103, 0x002081B3, 0x40118233, 0x0040E2B3, 0x0012E313, 0x00612023, 0x004123B3, 0x00812413, 0xFE518AE3, 0x00000000 (little-endian); DM bytes 0..8 = 0..8, DM[12]=4, DM[9..11,13..15]=0.
- Reset low, then release -> PC=0, instruction=0x00800093, imm_extended=8, X0..X8=0.
- Step 6 cycles -> X1=8, X2=4 (lw from address 12, mem_adr=12), X3=12, X4=4, X5=12, X6=13; PC=24.
- Next cycle (sw at PC 24) -> DM_4=13 afterwards, mem_adr=4; DM_12 stays 4.
- Two more cycles -> X7=0 (slt 4<4), X8=1 (slti 4<8).
- At PC=36, beq x3,x5 with 12==12 -> imm_extended=0xFFFFFFF4, next PC=24. The loop 24->28->32->36->24 repeats indefinitely with register values stable.
- Assert reset mid-loop -> PC=0 and X1..X8=0 immediately, without waiting for a clock edge; DM_4 remains 13.
